// File: rtl/mpu_pkg.sv
// mpu_pkg: shared definitions for the mpu_seq sequencer.
//   - 2-bit opcode constants (OP_ADD/OP_SUB/OP_MUL/OP_AND)
//   - FSM state encoding (S_IDLE, S_MUL, S_HOLD)
package mpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/mpu_alu.sv
// mpu_alu: single-cycle add/sub/and datapath for mpu_seq.
//   op  : opcode (OP_MUL yields 0; the multiplier lives in mpu_seq)
//   a,b : W-bit operands
//   res : W+1 bit result; bit W is carry (add) or borrow (sub)
module mpu_alu
  import mpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   res
);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      // Modulo 2^(W+1) difference: bit W reads as the borrow.
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_AND:  res = {1'b0, a & b};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mpu_seq.sv
// mpu_seq: valid/ready instruction sequencer with add/sub/and in one cycle
// and an iterative shift-add multiply (W cycles).
// Optional feature macro: MPU_SEQ_MUL_EN (multiplier present when defined;
// otherwise op 10 completes in one cycle with out=0, err=1).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : instruction handshake, instr = {op, a, b}
//   out_valid/out_ready : result handshake
//   out                 : 2*W-bit result, err : unsupported op flag
module mpu_seq
  import mpu_pkg::*;
#(
  parameter  int W       = 8,
  localparam int INSTR_W = 2*W+2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out,
  output logic               err
);

  state_t state, state_d;

  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W:0]   alu_res;
  logic         take;
  logic         is_mul;

  assign op = instr[INSTR_W-1 -: 2];
  assign a  = instr[2*W-1:W];
  assign b  = instr[W-1:0];

  mpu_alu #(.W(W)) u_alu (.op(op), .a(a), .b(b), .res(alu_res));

`ifdef MPU_SEQ_MUL_EN
  localparam int CW = $clog2(W+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W-1);

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, mcand, acc_nxt;
  logic [W-1:0]   mplier;

  assign is_mul  = (op == OP_MUL);
  assign acc_nxt = mplier[0] ? acc + mcand : acc;
`else
  assign is_mul  = 1'b0;
`endif

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign take      = in_valid && in_ready;
  assign out_valid = (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (take) state_d = is_mul ? S_MUL : S_HOLD;
`ifdef MPU_SEQ_MUL_EN
      S_MUL:  if (cnt == CNT_LAST) state_d = S_HOLD;
`endif
      S_HOLD: if (out_ready) begin
        if (take) state_d = is_mul ? S_MUL : S_HOLD;
        else      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
      err <= 1'b0;
`ifdef MPU_SEQ_MUL_EN
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      if (take) begin
        if (op == OP_MUL) begin
`ifdef MPU_SEQ_MUL_EN
          acc    <= '0;
          cnt    <= '0;
          mcand  <= {{W{1'b0}}, a};
          mplier <= b;
`else
          out <= '0;
          err <= 1'b1;
`endif
        end else begin
          out <= {{(W-1){1'b0}}, alu_res};
          err <= 1'b0;
        end
      end
`ifdef MPU_SEQ_MUL_EN
      // One shift-add step per MUL cycle; the last step lands in out.
      if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt != CNT_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          out <= acc_nxt;
          err <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: doc/mpu_seq.md
MPU_SEQ -- requirements
Module: mpu_seq

Interface
REQ-001 Parameter W, default 8, operand width in bits, legal range 4..32.
REQ-002 Parameter INSTR_W, default 2*W+2, instruction width, derived and not overridden.
REQ-003 Port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, synchronous active-low reset, sampled on rising clk.
REQ-005 Port in_valid, input, 1 bit, instruction on instr is valid.
REQ-006 Port in_ready, output, 1 bit, block accepts instr this cycle.
REQ-007 Port instr, input, INSTR_W bits, layout {op[1:0], a[W-1:0], b[W-1:0]}, op at the MSBs.
REQ-008 Port out_valid, output, 1 bit, result on out/err is valid.
REQ-009 Port out_ready, input, 1 bit, consumer takes the result this cycle.
REQ-010 Port out, output, 2*W bits, result, zero-extended where narrower.
REQ-011 Port err, output, 1 bit, the instruction was unsupported; qualified by out_valid.

Function
REQ-012 The transfer rules SHALL be: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-013 The opcodes SHALL be:
- 00 add: out[W:0] = a+b, bit W = carry.
- 01 sub: out[W:0] = a-b mod 2^(W+1), bit W = borrow.
- 10 mul: out = a*b, full 2*W bits.
- 11 and: out[W-1:0] = a&b.
REQ-014 The FSM SHALL have three states: IDLE, MUL (iterative multiply), HOLD (result presented).
REQ-015 In IDLE on input transfer, the FSM SHALL behave as follows:
- op != 10: register the result and go to HOLD, so out_valid asserts the next cycle (latency 1).
- op == 10: load the operands, clear the accumulator and counter, and go to MUL.
REQ-016 In MUL, the block SHALL perform one shift-add step per cycle for exactly W cycles, then go to HOLD, so out_valid asserts W+1 cycles after acceptance; in_ready SHALL be 0 in MUL.
REQ-017 In HOLD, out, err and out_valid SHALL remain stable while out_ready=0.
REQ-018 In HOLD with out_ready=1, the FSM SHALL behave as follows:
- with an input transfer in the same cycle, process the new instr as in REQ-015 (back-to-back, throughput 1 per cycle for non-mul ops);
- otherwise go to IDLE and deassert out_valid.
REQ-019 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready), combinational from state and out_ready only, with no dependence on in_valid.
REQ-020 The MUL cycle counter SHALL be $clog2(W+1) bits wide and SHALL count 0..W-1 without wrapping past W-1.
REQ-021 err SHALL be 0 for all supported ops; out SHALL hold its last value when out_valid=0 and SHALL NOT be relied on.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, out_valid=0, out=0, err=0, and clear the counter and accumulator.
REQ-023 While rst_n=0, in_ready SHALL read 1 (state is IDLE), but no transfer SHALL be accepted on a reset edge.
REQ-024 Reset during MUL or HOLD SHALL discard the in-flight instruction with no partial result emitted.

Configuration
REQ-025 The macro MPU_SEQ_MUL_EN SHALL control the multiplier, as follows:
- defined: op 10 behaves as in REQ-015/016.
- undefined: the MUL state and shift-add datapath are absent; op 10 completes with latency 1, out=0, err=1.

Structure
REQ-026 The shared package mpu_pkg SHALL hold the opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_AND) and the FSM state encoding.
REQ-027 The combinational add/sub/and datapath SHALL be one sub-module, mpu_alu (parameter W; inputs op, a, b; output W+1 bits); the multiplier SHALL stay in mpu_seq.

Verification
REQ-028 Add (W=8): instr=18'b00_00000111_00000001, in_valid pulse, out_ready=1 -> next cycle out_valid=1, out=16'h0008, err=0.
REQ-029 Sub borrow: op=01, a=1, b=7 -> out=16'h01FA (bit 8 set), latency 1.
REQ-030 Mul: op=10, a=8'hFF, b=8'hFF -> in_ready=0 for 8 cycles, out_valid asserts 9 cycles after acceptance, out=16'hFE01; with MPU_SEQ_MUL_EN undefined -> out=0, err=1 at latency 1.
REQ-031 Backpressure/streaming: hold out_ready=0 for 5 cycles after an AND of a=8'hF0, b=8'h3C -> out=16'h0030 stable and in_ready=0; then stream 4 adds with in_valid=out_ready=1 -> one result per cycle, in order.
REQ-032 Reset mid-mul: assert rst_n=0 on the 3rd MUL cycle -> next edge state=IDLE, out_valid=0, out=0, no result emitted; a following add completes normally.
